// File: rtl/jt03_acc_seq_if.sv
// jt03_acc_seq_if: bus between the slot sequencer and its operator pipe / accumulator.
// master: drives clk_en, restart, the algorithm write port, op_in and snd_in; reads the sequencer outputs.
// slave:  the sequencer itself.
interface jt03_acc_seq_if;
  logic               clk_en;
  logic               restart;
  logic               wr;
  logic [1:0]         wr_ch;
  logic [2:0]         wr_alg;
  logic signed [13:0] op_in;
  logic signed [13:0] op_out;
  logic               s1_enters;
  logic               s2_enters;
  logic               s3_enters;
  logic               s4_enters;
  logic               zero;
  logic [2:0]         alg;
  logic signed [15:0] snd_in;
  logic signed [15:0] snd;
  logic               sample;
  logic [3:0]         slot;
  logic [1:0]         ch;
  modport master (
    output clk_en, restart, wr, wr_ch, wr_alg, op_in, snd_in,
    input  op_out, s1_enters, s2_enters, s3_enters, s4_enters, zero, alg, snd, sample, slot, ch
  );
  modport slave (
    input  clk_en, restart, wr, wr_ch, wr_alg, op_in, snd_in,
    output op_out, s1_enters, s2_enters, s3_enters, s4_enters, zero, alg, snd, sample, slot, ch
  );
endinterface

// File: rtl/jt03_acc_seq.sv
// jt03_acc_seq: 12-slot operator/channel sequencer feeding the accumulator and latching its sample.
// Ports:
//   clk, rst      single clock, asynchronous active-high reset
//   mute[2:0]     per-channel op_out mask, present only with JT03_ACC_SEQ_MUTE_EN defined
//   bus (slave)   clk_en/restart slot control, wr/wr_ch/wr_alg algorithm writes, op_in->op_out,
//                 s1..s4_enters/zero/alg/slot/ch sequencing outputs, snd_in->snd with sample strobe
// Optional feature macro: JT03_ACC_SEQ_MUTE_EN
module jt03_acc_seq (
  input  logic          clk,
  input  logic          rst,
`ifdef JT03_ACC_SEQ_MUTE_EN
  input  logic [2:0]    mute,
`endif
  jt03_acc_seq_if.slave bus
);
  logic [3:0]  slot_q, slot_d;
  logic [1:0]  ch_q, ch_d;
  logic [2:0]  alg_q [3];
  logic [2:0]  alg_d [3];
  logic [15:0] snd_q, snd_d;
  logic        sample_q, sample_d;
  logic        wrap;
  logic        muted;
  // ch is kept as its own mod-3 counter so slot mod 3 never needs a divider
  always_comb begin
    wrap     = bus.clk_en && !bus.restart && slot_q == 4'd11;
    slot_d   = bus.restart ? 4'd0 : !bus.clk_en ? slot_q : wrap ? 4'd0 : slot_q + 4'd1;
    ch_d     = bus.restart ? 2'd0 : !bus.clk_en ? ch_q : ch_q == 2'd2 ? 2'd0 : ch_q + 2'd1;
    snd_d    = wrap ? bus.snd_in : snd_q;
    sample_d = wrap;
    for (int i = 0; i < 3; i++)
      alg_d[i] = bus.wr && bus.wr_ch == 2'(i) ? bus.wr_alg : alg_q[i];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot_q   <= 4'd0;
      ch_q     <= 2'd0;
      snd_q    <= 16'd0;
      sample_q <= 1'b0;
      alg_q    <= '{default: 3'd0};
    end else begin
      slot_q   <= slot_d;
      ch_q     <= ch_d;
      snd_q    <= snd_d;
      sample_q <= sample_d;
      alg_q    <= alg_d;
    end
  // operator groups run in YM order S1, S3, S2, S4, three slots each
  assign bus.s1_enters = slot_q < 4'd3;
  assign bus.s3_enters = slot_q >= 4'd3 && slot_q < 4'd6;
  assign bus.s2_enters = slot_q >= 4'd6 && slot_q < 4'd9;
  assign bus.s4_enters = slot_q >= 4'd9;
  assign bus.zero      = slot_q == 4'd0;
  assign bus.slot      = slot_q;
  assign bus.ch        = ch_q;
  assign bus.alg       = ch_q == 2'd2 ? alg_q[2] : ch_q == 2'd1 ? alg_q[1] : alg_q[0];
  assign bus.snd       = snd_q;
  assign bus.sample    = sample_q;
`ifdef JT03_ACC_SEQ_MUTE_EN
  assign muted = ch_q == 2'd2 ? mute[2] : ch_q == 2'd1 ? mute[1] : mute[0];
`else
  assign muted = 1'b0;
`endif
  assign bus.op_out = muted ? 14'sd0 : bus.op_in;
endmodule

// File: tb/tb_jt03_acc_seq.sv
// tb_jt03_acc_seq: table vectors, hand sequences and randomized stimulus against a slot/round model.
module tb_jt03_acc_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef JT03_ACC_SEQ_MUTE_EN
  logic [2:0] mute = 3'd0;
`endif
  jt03_acc_seq_if bus ();
  jt03_acc_seq dut (
    .clk (clk),
    .rst (rst),
`ifdef JT03_ACC_SEQ_MUTE_EN
    .mute(mute),
`endif
    .bus (bus.slave)
  );
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int          m_slot;
  logic [2:0]  m_alg [3];
  logic [15:0] m_snd;
  bit          m_sample;

  typedef struct {
    int         slot;
    int         ch;
    logic [3:0] en;
    bit         zero;
    int         alg;
    bit         sample;
    logic [15:0] snd;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot = 0;
    m_snd = 16'd0;
    m_sample = 1'b0;
    for (int i = 0; i < 3; i++) m_alg[i] = 3'd0;
  endtask

  // one round = 12 slots; the sample taken at the end of a round appears for one cycle
  task automatic model_edge();
    m_sample = 1'b0;
    if (bus.restart) m_slot = 0;
    else if (bus.clk_en) begin
      if (m_slot == 11) begin
        m_snd = bus.snd_in;
        m_sample = 1'b1;
      end
      m_slot = (m_slot + 1) % 12;
    end
    if (bus.wr && bus.wr_ch < 3) m_alg[bus.wr_ch] = bus.wr_alg;
  endtask

  function automatic logic [13:0] exp_op();
`ifdef JT03_ACC_SEQ_MUTE_EN
    if (mute[m_slot % 3]) return 14'd0;
`endif
    return bus.op_in;
  endfunction

  task automatic check_all();
    int g;
    logic [3:0] en;
    g = m_slot / 3;
    en = g == 0 ? 4'b0001 : g == 1 ? 4'b0100 : g == 2 ? 4'b0010 : 4'b1000;
    chk("slot", {28'd0, bus.slot}, m_slot);
    chk("ch", {30'd0, bus.ch}, m_slot % 3);
    chk("zero", {31'd0, bus.zero}, m_slot == 0);
    chk("enters", {28'd0, bus.s4_enters, bus.s3_enters, bus.s2_enters, bus.s1_enters}, {28'd0, en});
    chk("alg", {29'd0, bus.alg}, {29'd0, m_alg[m_slot % 3]});
    chk("snd", {16'd0, bus.snd}, {16'd0, m_snd});
    chk("sample", {31'd0, bus.sample}, {31'd0, m_sample});
    chk("op_out", {18'd0, bus.op_out}, {18'd0, exp_op()});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    tbl[0]  = '{1,  1, 4'b0001, 0, 5, 0, 16'h0000};
    tbl[1]  = '{2,  2, 4'b0001, 0, 7, 0, 16'h0000};
    tbl[2]  = '{3,  0, 4'b0100, 0, 0, 0, 16'h0000};
    tbl[3]  = '{4,  1, 4'b0100, 0, 5, 0, 16'h0000};
    tbl[4]  = '{5,  2, 4'b0100, 0, 7, 0, 16'h0000};
    tbl[5]  = '{6,  0, 4'b0010, 0, 0, 0, 16'h0000};
    tbl[6]  = '{7,  1, 4'b0010, 0, 5, 0, 16'h0000};
    tbl[7]  = '{8,  2, 4'b0010, 0, 7, 0, 16'h0000};
    tbl[8]  = '{9,  0, 4'b1000, 0, 0, 0, 16'h0000};
    tbl[9]  = '{10, 1, 4'b1000, 0, 5, 0, 16'h0000};
    tbl[10] = '{11, 2, 4'b1000, 0, 7, 0, 16'h0000};
    tbl[11] = '{0,  0, 4'b0001, 1, 0, 1, 16'h1234};
    tbl[12] = '{1,  1, 4'b0001, 0, 5, 0, 16'h1234};
    bus.clk_en = 1'b0; bus.restart = 1'b0; bus.wr = 1'b0; bus.wr_ch = 2'd0; bus.wr_alg = 3'd0;
    bus.op_in = 14'sd0; bus.snd_in = 16'sd0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    // writes land while the sequencer is frozen; channel 3 does not exist
    bus.wr = 1'b1; bus.wr_ch = 2'd1; bus.wr_alg = 3'd5; tick();
    bus.wr_ch = 2'd2; bus.wr_alg = 3'd7; tick();
    bus.wr_ch = 2'd3; bus.wr_alg = 3'd6; tick();
    bus.wr = 1'b0;
    bus.snd_in = 16'sh1234; bus.clk_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("tbl_slot", {28'd0, bus.slot}, tbl[i].slot);
      chk("tbl_ch", {30'd0, bus.ch}, tbl[i].ch);
      chk("tbl_enters", {28'd0, bus.s4_enters, bus.s3_enters, bus.s2_enters, bus.s1_enters}, {28'd0, tbl[i].en});
      chk("tbl_zero", {31'd0, bus.zero}, {31'd0, tbl[i].zero});
      chk("tbl_alg", {29'd0, bus.alg}, tbl[i].alg);
      chk("tbl_sample", {31'd0, bus.sample}, {31'd0, tbl[i].sample});
      chk("tbl_snd", {16'd0, bus.snd}, {16'd0, tbl[i].snd});
    end
    repeat (10) tick();
    bus.snd_in = 16'shBEEF; tick();
    chk("wrap_snd", {16'd0, bus.snd}, 32'h0000BEEF);
    chk("wrap_sample", {31'd0, bus.sample}, 32'd1);
    bus.clk_en = 1'b0;
    repeat (5) tick();
    chk("frozen_sample", {31'd0, bus.sample}, 32'd0);
    chk("frozen_slot", {28'd0, bus.slot}, 32'd0);
    // write to the channel on the output this cycle
    bus.wr = 1'b1; bus.wr_ch = 2'd0; bus.wr_alg = 3'd3;
    #1 chk("alg_write_cycle", {29'd0, bus.alg}, 32'd0);
    tick();
    chk("alg_next_cycle", {29'd0, bus.alg}, 32'd3);
    bus.wr = 1'b0; bus.clk_en = 1'b1;
    repeat (7) tick();
    bus.restart = 1'b1; tick();
    chk("restart_slot", {28'd0, bus.slot}, 32'd0);
    chk("restart_snd", {16'd0, bus.snd}, 32'h0000BEEF);
    chk("restart_sample", {31'd0, bus.sample}, 32'd0);
    bus.restart = 1'b0;
    repeat (11) tick();
    bus.restart = 1'b1; bus.snd_in = 16'sh5555; tick();
    chk("restart11_snd", {16'd0, bus.snd}, 32'h0000BEEF);
    chk("restart11_sample", {31'd0, bus.sample}, 32'd0);
    bus.restart = 1'b0;
    repeat (6) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_slot", {28'd0, bus.slot}, 32'd0);
    chk("async_snd", {16'd0, bus.snd}, 32'd0);
    chk("async_alg", {29'd0, bus.alg}, 32'd0);
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_slot", {28'd0, bus.slot}, 32'd1);
    chk("post_rst_sample", {31'd0, bus.sample}, 32'd0);
    repeat (2) tick();
`ifdef JT03_ACC_SEQ_MUTE_EN
    bus.restart = 1'b1; tick();
    bus.restart = 1'b0;
    mute = 3'b010; bus.op_in = 14'sh0155;
    for (int i = 0; i < 12; i++) begin
      chk("mute_op", {18'd0, bus.op_out}, m_slot % 3 == 1 ? 32'd0 : 32'h155);
      tick();
    end
    mute = 3'd0;
`endif
    for (int i = 0; i < 3000; i++) begin
      bus.clk_en  = $urandom_range(0, 3) != 0;
      bus.restart = $urandom_range(0, 40) == 0;
      bus.wr      = $urandom_range(0, 4) == 0;
      bus.wr_ch   = 2'($urandom);
      bus.wr_alg  = 3'($urandom);
      bus.op_in   = 14'($urandom);
      bus.snd_in  = 16'($urandom);
`ifdef JT03_ACC_SEQ_MUTE_EN
      mute = 3'($urandom);
`endif
      #1 check_all();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt03_acc_seq.md
JT03_ACC_SEQ -- requirements
Module: jt03_acc_seq

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning): rst  in  1  asynchronous active-high reset.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 clk_en  in  1  slot advance enable.
REQ-004 restart  in  1  synchronous round restart.
REQ-005 wr  in  1  algorithm register write strobe; wr_ch  in  2  target channel; wr_alg  in  3  algorithm value.
REQ-006 op_in  in  14 signed  operator result from the operator pipe; op_out  out  14 signed  operator result forwarded to the accumulator.
REQ-007 s1_enters, s2_enters, s3_enters, s4_enters  out  1 each  operator-group flags for the accumulator.
REQ-008 zero  out  1  round-start flag for the accumulator; alg  out  3  algorithm of the current channel.
REQ-009 snd_in  in  16 signed  accumulator output; snd  out  16 signed  latched sample; sample  out  1  one-clk strobe marking a new snd.
REQ-010 slot  out  4  current slot index 0..11; ch  out  2  current channel 0..2.

Function
REQ-011 Slot counter SHALL advance by 1 on each clk edge with clk_en=1, wrapping 11->0.
REQ-012 Slot mapping SHALL be ch=slot mod 3; operator group=slot div 3 in YM order: 0=S1, 1=S3, 2=S2, 3=S4.
REQ-013 Exactly one of s1/s2/s3/s4_enters SHALL be high in every cycle, decoded from the registered slot (slots 0-2 s1, 3-5 s3, 6-8 s2, 9-11 s4).
REQ-014 zero SHALL be high exactly while slot==0.
REQ-015 alg SHALL equal the stored algorithm of channel ch, combinationally from registered state.
REQ-016 Algorithm registers (3 x 3 bits) SHALL update on a clk edge with wr=1; wr_ch=3 SHALL be ignored; new value visible from the next cycle.
REQ-017 Write to the channel currently being output SHALL not change alg in the write cycle; alg SHALL change in the following cycle.
REQ-018 On a clk edge with clk_en=1 and slot==11 (wrap to 0), snd SHALL capture snd_in and sample SHALL be high for exactly the following clk cycle.
REQ-019 sample SHALL be 0 in all other cycles, regardless of clk_en staying high.
REQ-020 restart=1 SHALL force slot to 0 at the next edge independent of clk_en, SHALL NOT capture snd, and SHALL NOT assert sample; restart has priority over clk_en.
REQ-021 clk_en=0 SHALL freeze slot, outputs and snd; writes SHALL still be accepted.
REQ-022 op_out SHALL equal op_in combinationally when the mute feature is absent or the current channel is not muted.

Reset
REQ-023 rst=1 SHALL asynchronously set slot=0, all algorithm registers=0, snd=0, sample=0 (hence zero=1, s1_enters=1, alg=0, ch=0).
REQ-024 rst mid-round SHALL abandon the round; after release the first clk_en edge SHALL move slot to 1 with no sample strobe.

Configuration
REQ-025 Macro JT03_ACC_SEQ_MUTE_EN SHALL, when defined, add input mute (3 bits, bit n = channel n) and force op_out=0 while mute[ch]=1; mask taken combinationally.
REQ-026 Without JT03_ACC_SEQ_MUTE_EN the mute port SHALL not exist and op_out SHALL always equal op_in.

Verification
REQ-027 Reset release, clk_en=1 for 12 cycles -> slot 0..11 then 0, enters pattern s1 x3, s3 x3, s2 x3, s4 x3, zero high only at slot 0.
REQ-028 Write ch1=5, ch2=7 -> at slots 1/4/7/10 alg=5, at slots 2/5/8/11 alg=7, ch0 slots alg=0; wr_ch=3 with alg=6 -> no register change.
REQ-029 snd_in=0x1234 held, slot 11 with clk_en -> snd=0x1234, sample high one clk; clk_en held low 5 cycles after -> sample stays 0, slot stays 0.
REQ-030 restart at slot 7 with clk_en=1 -> slot=0 next cycle, snd unchanged, sample=0.
REQ-031 Assert rst at slot 6 -> slot=0, alg registers 0, snd=0 immediately (before any clk edge).
REQ-032 With JT03_ACC_SEQ_MUTE_EN, mute=3'b010, op_in=0x0155 -> op_out=0 at slots 1,4,7,10, op_out=0x0155 at other slots.
